seyahat_yonetici: RTL

SEYAHAT_YONETICI -- requirements
Module: seyahat_yonetici

---
 rtl/seyahat_yonetici_if.sv | 27 ++
 rtl/seyahat_yonetici.sv | 93 +++++++++
 2 files changed

// File: rtl/seyahat_yonetici_if.sv
// Request and status bundle for the trip manager: the controller side drives
// the start/abort/pause requests, the manager side reports trip progress.
interface seyahat_yonetici_if;
   logic       basla;
   logic [3:0] yakit;
   logic [5:0] rota;
   logic       seyahat_dogru;
   logic       iptal;
   logic       duraklat;
   logic [1:0] durum;
   logic       mesgul;
   logic [1:0] konum;
   logic [3:0] kalan_yakit;
   logic [5:0] rota_kayit;
   logic       tamam;
   logic       hata;

   modport master (
      output basla, yakit, rota, seyahat_dogru, iptal, duraklat,
      input  durum, mesgul, konum, kalan_yakit, rota_kayit, tamam, hata
   );

   modport slave (
      input  basla, yakit, rota, seyahat_dogru, iptal, duraklat,
      output durum, mesgul, konum, kalan_yakit, rota_kayit, tamam, hata
   );
endinterface

// File: rtl/seyahat_yonetici.sv
// Trip manager: accepts a validated start, burns one fuel unit per active
// cycle, and reports three completed legs of four steps each.
module seyahat_yonetici (
   input  logic                clk,
   input  logic                rst_n,
   seyahat_yonetici_if.slave   bus
);

   typedef enum logic [1:0] {
      BOSTA = 2'b00,
      YOLDA = 2'b01,
      VARDI = 2'b10,
      HATA  = 2'b11
   } durum_t;

   durum_t     state, state_d;
   logic [1:0] adim, adim_d;
   logic [1:0] konum_q, konum_d;
   logic [3:0] yakit_q, yakit_d;
   logic [5:0] rota_q, rota_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= BOSTA;
         adim    <= 2'd0;
         konum_q <= 2'd0;
         yakit_q <= 4'd0;
         rota_q  <= 6'd0;
      end else begin
         state   <= state_d;
         adim    <= adim_d;
         konum_q <= konum_d;
         yakit_q <= yakit_d;
         rota_q  <= rota_d;
      end
   end

   // Priority in YOLDA: abort, then pause, then the empty-tank guard, then advance.
   always_comb begin
      state_d = state;
      adim_d  = adim;
      konum_d = konum_q;
      yakit_d = yakit_q;
      rota_d  = rota_q;
      case (state)
         BOSTA: begin
            if (bus.basla) begin
               if (bus.seyahat_dogru) begin
                  yakit_d = bus.yakit;
                  rota_d  = bus.rota;
                  konum_d = 2'd0;
                  adim_d  = 2'd0;
                  state_d = YOLDA;
               end else begin
                  state_d = HATA;
               end
            end
         end
         YOLDA: begin
            if (bus.iptal) begin
               state_d = BOSTA;
            end else if (bus.duraklat) begin
               state_d = YOLDA;
            end else if (yakit_q == 4'd0) begin
               state_d = HATA;
            end else begin
               yakit_d = yakit_q - 4'd1;
               if (adim == 2'd3) begin
                  adim_d  = 2'd0;
                  konum_d = konum_q + 2'd1;
                  if (konum_q == 2'd2) begin
                     state_d = VARDI;
                  end
               end else begin
                  adim_d = adim + 2'd1;
               end
            end
         end
         VARDI:   state_d = BOSTA;
         HATA:    state_d = BOSTA;
         default: state_d = BOSTA;
      endcase
   end

   assign bus.durum       = state;
   assign bus.mesgul      = (state == YOLDA);
   assign bus.tamam       = (state == VARDI);
   assign bus.hata        = (state == HATA);
   assign bus.konum       = konum_q;
   assign bus.kalan_yakit = yakit_q;
   assign bus.rota_kayit  = rota_q;

endmodule
